// File: rtl/radio_seq_pkg.sv
// -----------------------------------------------------------------------------
// radio_seq_pkg
// Shared types and default timing constants for the radio reset sequencer.
//   ch_state_t : per-channel sequencing state (OFF, ASSERT, BOOT, READY)
//   DEF_*      : default cycle counts for a 50 MHz system clock
//   is_busy()  : true while a channel is mid-sequence (ASSERT or BOOT)
// Optional feature macro: RADIO_WATCHDOG_EN (only DEF_WDT_CYCLES relates to it).
// -----------------------------------------------------------------------------
package radio_seq_pkg;

  typedef enum logic [1:0] {
    OFF    = 2'd0,
    ASSERT = 2'd1,
    BOOT   = 2'd2,
    READY  = 2'd3
  } ch_state_t;

  localparam int DEF_NUM_CH         = 2;
  localparam int DEF_RST_CYCLES     = 500000;     // 10 ms
  localparam int DEF_BOOT_CYCLES    = 25000000;   // 500 ms
  localparam int DEF_STAGGER_CYCLES = 2500000;    // 50 ms
  localparam int DEF_WDT_CYCLES     = 100000000;  // 2 s
  localparam int DEF_CNT_W          = 32;

  function automatic logic is_busy(input ch_state_t s);
    return (s == ASSERT) || (s == BOOT);
  endfunction

endpackage

// File: rtl/radio_seq_ch.sv
// -----------------------------------------------------------------------------
// radio_seq_ch
// One radio channel: power-enable / reset-pulse / boot-wait state machine.
// Ports:
//   clk        system clock
//   srst_n     synchronous active-low reset
//   en_req     power request for this channel
//   gate       stagger gate from the top; channel may leave OFF only when high
//   rst_src    combined reset source (software reset or synchronised key)
//   alive      (RADIO_WATCHDOG_EN only) RX activity pulse
//   wdt_trip   (RADIO_WATCHDOG_EN only) sticky watchdog trip flag
//   dev_en     module enable pin
//   dev_rst_n  module reset pin, active-low
//   ready      channel booted, UART usable
//   busy       channel is in ASSERT or BOOT
// Optional feature macro: RADIO_WATCHDOG_EN
// -----------------------------------------------------------------------------
module radio_seq_ch
  import radio_seq_pkg::*;
#(
  parameter int RST_CYCLES  = DEF_RST_CYCLES,
  parameter int BOOT_CYCLES = DEF_BOOT_CYCLES,
  parameter int CNT_W       = DEF_CNT_W
`ifdef RADIO_WATCHDOG_EN
  ,
  parameter int WDT_CYCLES  = DEF_WDT_CYCLES
`endif
) (
  input  logic clk,
  input  logic srst_n,
  input  logic en_req,
  input  logic gate,
  input  logic rst_src,
`ifdef RADIO_WATCHDOG_EN
  input  logic alive,
  output logic wdt_trip,
`endif
  output logic dev_en,
  output logic dev_rst_n,
  output logic ready,
  output logic busy
);

  localparam logic [CNT_W-1:0] RST_LAST  = CNT_W'(RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] BOOT_LAST = CNT_W'(BOOT_CYCLES - 1);
`ifdef RADIO_WATCHDOG_EN
  localparam logic [CNT_W-1:0] WDT_LAST  = CNT_W'(WDT_CYCLES - 1);
  logic [CNT_W-1:0] wdt_q, wdt_d;
  logic             trip_q, trip_d;
`endif

  ch_state_t        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             dev_en_q, dev_en_d;
  logic             dev_rst_n_q, dev_rst_n_d;
  logic             ready_q, ready_d;
  logic             busy_q, busy_d;

  // Priority: dropped request beats a reset source, which beats progression.
  // Outputs are decoded from the next state so they toggle on the same edge
  // as the state change.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
`ifdef RADIO_WATCHDOG_EN
    wdt_d   = '0;
    trip_d  = trip_q;
`endif
    if (!en_req) begin
      state_d = OFF;
      cnt_d   = '0;
`ifdef RADIO_WATCHDOG_EN
      trip_d  = 1'b0;
`endif
    end else if (rst_src && (state_q == BOOT || state_q == READY)) begin
      state_d = ASSERT;
      cnt_d   = '0;
    end else begin
      case (state_q)
        OFF: begin
          if (gate) begin
            state_d = ASSERT;
            cnt_d   = '0;
          end
        end
        ASSERT: begin
          // Holding the count at zero while the source is active guarantees
          // a full pulse after the source releases.
          if (rst_src) begin
            cnt_d = '0;
          end else if (cnt_q == RST_LAST) begin
            state_d = BOOT;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        BOOT: begin
          if (cnt_q == BOOT_LAST) begin
            state_d = READY;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        READY: begin
`ifdef RADIO_WATCHDOG_EN
          if (alive) begin
            wdt_d = '0;
          end else if (wdt_q == WDT_LAST) begin
            state_d = ASSERT;
            cnt_d   = '0;
            trip_d  = 1'b1;
          end else begin
            wdt_d = wdt_q + 1'b1;
          end
`endif
        end
        default: begin
          state_d = OFF;
          cnt_d   = '0;
        end
      endcase
    end
    dev_en_d    = (state_d != OFF);
    dev_rst_n_d = (state_d == BOOT) || (state_d == READY);
    ready_d     = (state_d == READY);
    busy_d      = is_busy(state_d);
  end

  always_ff @(posedge clk) begin
    if (!srst_n) begin
      state_q     <= OFF;
      cnt_q       <= '0;
      dev_en_q    <= 1'b0;
      dev_rst_n_q <= 1'b0;
      ready_q     <= 1'b0;
      busy_q      <= 1'b0;
`ifdef RADIO_WATCHDOG_EN
      wdt_q       <= '0;
      trip_q      <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      dev_en_q    <= dev_en_d;
      dev_rst_n_q <= dev_rst_n_d;
      ready_q     <= ready_d;
      busy_q      <= busy_d;
`ifdef RADIO_WATCHDOG_EN
      wdt_q       <= wdt_d;
      trip_q      <= trip_d;
`endif
    end
  end

  assign dev_en    = dev_en_q;
  assign dev_rst_n = dev_rst_n_q;
  assign ready     = ready_q;
  assign busy      = busy_q;
`ifdef RADIO_WATCHDOG_EN
  assign wdt_trip  = trip_q;
`endif

endmodule

// File: rtl/radio_reset_sequencer.sv
// -----------------------------------------------------------------------------
// radio_reset_sequencer
// Power-enable and reset sequencer for NUM_CH UART-attached radio modules.
// Owns the KEY synchroniser, the power-up stagger timer and the busy summary;
// each channel's sequencing lives in radio_seq_ch.
// Ports:
//   clk_clk        system clock
//   reset_reset_n  synchronous active-low reset
//   key_n          raw pushbutton, active-low, asynchronous (resets all channels)
//   sw_rst_n       per-channel software reset, active-low level
//   ch_en_req      per-channel power request
//   ch_alive       (RADIO_WATCHDOG_EN only) per-channel RX activity pulse
//   wdt_trip       (RADIO_WATCHDOG_EN only) per-channel sticky watchdog flag
//   dev_en         module enable pins
//   dev_rst_n      module reset pins, active-low
//   ch_ready       channel booted
//   busy           any channel in ASSERT or BOOT
// Optional feature macro: RADIO_WATCHDOG_EN
// -----------------------------------------------------------------------------
module radio_reset_sequencer
  import radio_seq_pkg::*;
#(
  parameter int NUM_CH         = DEF_NUM_CH,
  parameter int RST_CYCLES     = DEF_RST_CYCLES,
  parameter int BOOT_CYCLES    = DEF_BOOT_CYCLES,
  parameter int STAGGER_CYCLES = DEF_STAGGER_CYCLES,
  parameter int CNT_W          = DEF_CNT_W
`ifdef RADIO_WATCHDOG_EN
  ,
  parameter int WDT_CYCLES     = DEF_WDT_CYCLES
`endif
) (
  input  logic              clk_clk,
  input  logic              reset_reset_n,
  input  logic              key_n,
  input  logic [NUM_CH-1:0] sw_rst_n,
  input  logic [NUM_CH-1:0] ch_en_req,
`ifdef RADIO_WATCHDOG_EN
  input  logic [NUM_CH-1:0] ch_alive,
  output logic [NUM_CH-1:0] wdt_trip,
`endif
  output logic [NUM_CH-1:0] dev_en,
  output logic [NUM_CH-1:0] dev_rst_n,
  output logic [NUM_CH-1:0] ch_ready,
  output logic              busy
);

  localparam logic [CNT_W-1:0] TIMER_MAX = CNT_W'((NUM_CH - 1) * STAGGER_CYCLES);

  logic             key_meta_q, key_meta_d;
  logic             key_sync_q, key_sync_d;
  logic [CNT_W-1:0] timer_q, timer_d;

  logic [NUM_CH-1:0] gate;
  logic [NUM_CH-1:0] rst_src;
  logic [NUM_CH-1:0] ch_busy;

  // Stagger timer saturates so the gates, once open, stay open until reset.
  always_comb begin
    key_meta_d = key_n;
    key_sync_d = key_meta_q;
    timer_d    = (timer_q >= TIMER_MAX) ? timer_q : timer_q + 1'b1;
  end

  // Synchroniser flops reset to 1 so a reset never looks like a key press.
  always_ff @(posedge clk_clk) begin
    if (!reset_reset_n) begin
      key_meta_q <= 1'b1;
      key_sync_q <= 1'b1;
      timer_q    <= '0;
    end else begin
      key_meta_q <= key_meta_d;
      key_sync_q <= key_sync_d;
      timer_q    <= timer_d;
    end
  end

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    assign gate[i]    = (timer_q >= CNT_W'(i * STAGGER_CYCLES));
    assign rst_src[i] = ~sw_rst_n[i] | ~key_sync_q;

    radio_seq_ch #(
      .RST_CYCLES  (RST_CYCLES),
      .BOOT_CYCLES (BOOT_CYCLES),
      .CNT_W       (CNT_W)
`ifdef RADIO_WATCHDOG_EN
      ,
      .WDT_CYCLES  (WDT_CYCLES)
`endif
    ) u_ch (
      .clk       (clk_clk),
      .srst_n    (reset_reset_n),
      .en_req    (ch_en_req[i]),
      .gate      (gate[i]),
      .rst_src   (rst_src[i]),
`ifdef RADIO_WATCHDOG_EN
      .alive     (ch_alive[i]),
      .wdt_trip  (wdt_trip[i]),
`endif
      .dev_en    (dev_en[i]),
      .dev_rst_n (dev_rst_n[i]),
      .ready     (ch_ready[i]),
      .busy      (ch_busy[i])
    );
  end

  assign busy = |ch_busy;

endmodule

// File: doc/radio_reset_sequencer.md
Name: radio_reset_sequencer

Overview:
Parametrised power-enable and reset sequencer for N UART-attached radio modules (Wi-Fi, Bluetooth, future channels) on the GPIO headers. Replaces the per-module glue (enable tied high, reset = key AND software PIO) with a per-channel state machine that does the following:
- enforces a minimum reset pulse and a boot wait;
- staggers power-up across channels;
- reports readiness to the Nios PIO.

Sits between the Qsys PIO exports, KEY inputs and GPIO_1 pins.

Parameters:
- NUM_CH, 2, number of radio channels.
- RST_CYCLES, 500000, minimum dev_rst_n low time in clocks (10 ms at 50 MHz).
- BOOT_CYCLES, 25000000, wait after reset release before ch_ready (500 ms).
- STAGGER_CYCLES, 2500000, delay between successive channels leaving OFF after system reset.
- CNT_W, 32, width of all internal counters. Must hold max(RST_CYCLES, BOOT_CYCLES, (NUM_CH-1)*STAGGER_CYCLES).

Ports:
- clk_clk  in  1  system clock (CLOCK_50).
- reset_reset_n  in  1  synchronous active-low reset.
- key_n  in  1  raw pushbutton, active-low, asynchronous; 2-flop synchronised internally.
- sw_rst_n  in  NUM_CH  per-channel software reset from PIO, active-low level.
- ch_en_req  in  NUM_CH  per-channel power request from PIO.
- dev_en  out  NUM_CH  module enable pin (e.g. WIFI_EN).
- dev_rst_n  out  NUM_CH  module reset pin, active-low.
- ch_ready  out  NUM_CH  channel booted, UART usable.
- busy  out  1  OR of all channels in ASSERT or BOOT.

Behaviour:
- Reset values: dev_en=0, dev_rst_n=0, ch_ready=0, busy=0, all counters 0, all channels OFF, key synchroniser flops = 1.
- Stagger timer: global counter starts at 0 after reset and saturates at (NUM_CH-1)*STAGGER_CYCLES. Channel i is gated, i.e. cannot leave OFF, until timer >= i*STAGGER_CYCLES. The gate never closes again until reset.
- Reset source per channel: rst_src[i] = ~sw_rst_n[i] | ~key_sync. The key resets all channels.
- Per-channel FSM:
  - OFF: en=0, rst_n=0, ready=0. Go to ASSERT when ch_en_req[i] & gate[i]; load cnt=0.
  - ASSERT: en=1, rst_n=0. cnt increments each cycle while rst_src=0. While rst_src=1, cnt is held at 0, so the pulse lasts at least RST_CYCLES after the source releases. Go to BOOT when cnt==RST_CYCLES-1 and rst_src=0; reload cnt=0.
  - BOOT: en=1, rst_n=1, ready=0. Go to READY at cnt==BOOT_CYCLES-1.
  - READY: en=1, rst_n=1, ready=1.
- Priority, highest first, applying in every state:
  1. ch_en_req[i]=0 → OFF next cycle.
  2. rst_src=1 in BOOT or READY → ASSERT next cycle with cnt=0.
  3. Normal progression.
- Outputs are registered from state and change on the clock edge of the state change.
- Latency: with gate open, ch_en_req rising at edge k gives:
  - dev_en=1 after edge k+1;
  - dev_rst_n=1 after edge k+1+RST_CYCLES;
  - ch_ready=1 after edge k+1+RST_CYCLES+BOOT_CYCLES.
- Edge cases:
  - ch_en_req dropped mid-ASSERT/BOOT aborts immediately.
  - Re-request restarts the full sequence; no partial credit.
  - reset_reset_n low at any time returns everything to reset values on the next edge.
- Channels are fully independent apart from the shared gate and key.

Optional Feature:
RADIO_WATCHDOG_EN. When defined, the block adds:
- Parameter WDT_CYCLES (default 100000000).
- Input ch_alive[NUM_CH]: any RX activity pulse.
- Output wdt_trip[NUM_CH]: sticky flag, cleared by ch_en_req low.

Watchdog behaviour when defined:
- In READY, a per-channel counter counts cycles since the last ch_alive pulse.
- On reaching WDT_CYCLES-1 the channel goes to ASSERT (auto-reset) and sets wdt_trip.
- The counter is cleared on ch_alive and whenever the channel is not in READY.

When not defined: the ports and parameter are absent, and no watchdog logic is present.

Decomposition:
- Package radio_seq_pkg holds:
  - ch_state_t enum {OFF, ASSERT, BOOT, READY} (2-bit);
  - default cycle constants.
- One sub-module, radio_seq_ch: one channel FSM plus its counter(s). The top generates NUM_CH instances and owns the key synchroniser, the stagger timer and busy.

Test Plan (NUM_CH=2, RST_CYCLES=4, BOOT_CYCLES=3, STAGGER_CYCLES=5, WDT_CYCLES=6, key_n=1, sw_rst_n=2'b11):
- Power-up: release reset with ch_en_req=2'b11 → dev_en[0] at cycle 1, dev_rst_n[0] at 5, ch_ready[0] at 8. Channel 1 follows the same timing shifted by 5 cycles; busy high over cycles 1–12.
- SW reset: in READY, sw_rst_n[0] held low for 10 cycles → dev_rst_n[0] low from the next edge until 4 cycles after release, ch_ready[0] returns 3 cycles later; channel 1 unaffected.
- Key reset: key_n low for 2 cycles while both channels are READY → both go to ASSERT 3 cycles later (synchroniser plus FSM); each dev_rst_n stays low for at least 4 cycles after the synchronised release.
- Abort: drop ch_en_req[1] during BOOT → dev_en[1]=0, dev_rst_n[1]=0, ch_ready[1]=0 next cycle. Re-raise it → full 1+4+3 sequence with no stagger wait.
- Simultaneous: ch_en_req low and sw_rst_n low on the same cycle → OFF wins; reset_reset_n low mid-BOOT → all outputs 0 next edge.
- RADIO_WATCHDOG_EN: no ch_alive for 6 cycles in READY → ASSERT and wdt_trip=1. A ch_alive pulse every 4 cycles → no trip.
